// File: rtl/sdram_burst_writer.sv
// Avalon-MM burst writer: drains a show-ahead FIFO into an SDRAM word window,
// with one-shot or circular addressing and a drain-on-terminate stop.
module sdram_burst_writer #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 27,
  parameter int BURST_MAX = 8,
  parameter int BC_W      = 8,
  parameter int LEVEL_W   = 9
) (
  input  logic                sdram_clk,
  input  logic                rst_sdram,
  input  logic                fill_launch,
  input  logic                fill_terminate,
  input  logic                fill_circular,
  input  logic [ADDR_W-1:0]   fill_addr_start,
  input  logic [ADDR_W-1:0]   fill_addr_end,
  output logic                fill_running,
  output logic                fill_wrapped,
  output logic [ADDR_W-1:0]   fill_last_addr,
  input  logic [DATA_W-1:0]   fifo_q,
  input  logic [LEVEL_W-1:0]  fifo_usedw,
  output logic                fifo_rdreq,
  output logic [ADDR_W-1:0]   sdram_address,
  output logic [BC_W-1:0]     sdram_burstcount,
  input  logic                sdram_waitrequest,
  output logic                sdram_write,
  output logic [DATA_W-1:0]   sdram_writedata,
  output logic                sdram_read,
  output logic [DATA_W/8-1:0] sdram_byteenable
);

  // Common width for comparing remaining window space against the FIFO level.
  localparam int CW1 = (ADDR_W + 1 > LEVEL_W) ? ADDR_W + 1 : LEVEL_W;
  localparam int CW  = (CW1 > BC_W) ? CW1 : BC_W;

  typedef enum logic [1:0] {IDLE, PLAN, BURST} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   start_r, end_r, addr;
  logic                circ_r, term_r;
  logic [BC_W-1:0]     beat_cnt, len;
  logic                issue, accept, last_beat, at_end;
  logic [ADDR_W:0]     rem;
  logic [CW-1:0]       rem_x, want, level;
  logic [ADDR_W-1:0]   beat_addr;

  assign sdram_writedata  = fifo_q;
  assign sdram_read       = 1'b0;
  assign sdram_byteenable = '1;

  always_ff @(posedge sdram_clk) begin
    if (rst_sdram) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    rem        = {1'b0, end_r} - {1'b0, addr} + (ADDR_W + 1)'(1);
    rem_x      = CW'(rem);
    want       = (rem_x < CW'(BURST_MAX)) ? rem_x : CW'(BURST_MAX);
    level      = CW'(fifo_usedw);
    accept     = sdram_write && !sdram_waitrequest;
    last_beat  = accept && (beat_cnt == sdram_burstcount - BC_W'(1));
    beat_addr  = sdram_address + ADDR_W'(beat_cnt);
    at_end     = (beat_addr == end_r);
    fifo_rdreq = accept;
    state_next = state;
    issue      = 1'b0;
    len        = '0;
    case (state)
      IDLE: if (fill_launch) state_next = PLAN;
      PLAN: begin
        // A short burst is only allowed once terminate has been latched.
        if (level >= want) begin
          issue = 1'b1;
          len   = BC_W'(want);
        end else if (term_r && level != '0) begin
          issue = 1'b1;
          len   = BC_W'(level);
        end else if (term_r) begin
          state_next = IDLE;
        end
        if (issue) state_next = BURST;
      end
      BURST: if (last_beat) state_next = (at_end && !circ_r) ? IDLE : PLAN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (rst_sdram) begin
      start_r          <= '0;
      end_r            <= '0;
      addr             <= '0;
      circ_r           <= 1'b0;
      term_r           <= 1'b0;
      beat_cnt         <= '0;
      sdram_address    <= '0;
      sdram_burstcount <= '0;
      sdram_write      <= 1'b0;
      fill_running     <= 1'b0;
      fill_wrapped     <= 1'b0;
      fill_last_addr   <= '0;
    end else begin
      fill_running <= (state_next != IDLE);
      if (state != IDLE && fill_terminate) term_r <= 1'b1;
      case (state)
        IDLE: if (fill_launch) begin
          start_r      <= fill_addr_start;
          end_r        <= fill_addr_end;
          circ_r       <= fill_circular;
          addr         <= fill_addr_start;
          fill_wrapped <= 1'b0;
          term_r       <= 1'b0;
        end
        PLAN: if (issue) begin
          sdram_address    <= addr;
          sdram_burstcount <= len;
          beat_cnt         <= '0;
          sdram_write      <= 1'b1;
        end
        BURST: if (accept) begin
          beat_cnt       <= beat_cnt + BC_W'(1);
          fill_last_addr <= beat_addr;
          if (last_beat) begin
            sdram_write <= 1'b0;
            // Bursts never straddle the window end, so a wrap restarts at start.
            if (at_end) begin
              if (circ_r) begin
                addr         <= start_r;
                fill_wrapped <= 1'b1;
              end
            end else begin
              addr <= addr + ADDR_W'(sdram_burstcount);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench for sdram_burst_writer: behavioural show-ahead FIFO, bus
// monitor, and one task per scenario with hand-computed expectations.
module tb_sdram_burst_writer;

  localparam int DATA_W = 256, ADDR_W = 27, BURST_MAX = 8, BC_W = 8, LEVEL_W = 9;

  logic                sdram_clk = 1'b0;
  logic                rst_sdram = 1'b1;
  logic                fill_launch = 1'b0, fill_terminate = 1'b0, fill_circular = 1'b0;
  logic [ADDR_W-1:0]   fill_addr_start = '0, fill_addr_end = '0;
  logic                fill_running, fill_wrapped;
  logic [ADDR_W-1:0]   fill_last_addr;
  logic [DATA_W-1:0]   fifo_q;
  logic [LEVEL_W-1:0]  fifo_usedw;
  logic                fifo_rdreq;
  logic [ADDR_W-1:0]   sdram_address;
  logic [BC_W-1:0]     sdram_burstcount;
  logic                sdram_waitrequest = 1'b0;
  logic                sdram_write, sdram_read;
  logic [DATA_W-1:0]   sdram_writedata;
  logic [DATA_W/8-1:0] sdram_byteenable;

  int vectors = 0;
  int miscompares = 0;

  sdram_burst_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX),
                       .BC_W(BC_W), .LEVEL_W(LEVEL_W)) dut (
    .sdram_clk(sdram_clk), .rst_sdram(rst_sdram),
    .fill_launch(fill_launch), .fill_terminate(fill_terminate),
    .fill_circular(fill_circular), .fill_addr_start(fill_addr_start),
    .fill_addr_end(fill_addr_end), .fill_running(fill_running),
    .fill_wrapped(fill_wrapped), .fill_last_addr(fill_last_addr),
    .fifo_q(fifo_q), .fifo_usedw(fifo_usedw), .fifo_rdreq(fifo_rdreq),
    .sdram_address(sdram_address), .sdram_burstcount(sdram_burstcount),
    .sdram_waitrequest(sdram_waitrequest), .sdram_write(sdram_write),
    .sdram_writedata(sdram_writedata), .sdram_read(sdram_read),
    .sdram_byteenable(sdram_byteenable)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Show-ahead FIFO model
  logic              push = 1'b0, fifo_flush = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic [DATA_W-1:0] mem [0:255];
  logic [7:0]        rd_ptr = '0, wr_ptr = '0;
  logic [7:0]        fill_diff;

  always @(posedge sdram_clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else begin
      if (fifo_rdreq) rd_ptr <= rd_ptr + 8'd1;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 8'd1;
      end
    end
  end
  assign fifo_q     = mem[rd_ptr];
  assign fill_diff  = wr_ptr - rd_ptr;
  assign fifo_usedw = {1'b0, fill_diff};

  // Bus monitor, sampled on the falling edge
  logic [ADDR_W-1:0] b_addr [0:63];
  logic [BC_W-1:0]   b_bc   [0:63];
  logic              b_wrap [0:63];
  logic [DATA_W-1:0] beat_data [0:255];
  int nb = 0, nbeat = 0, npop = 0, nstall = 0, stall_err = 0;
  logic              prev_write = 1'b0, prev_wait = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [BC_W-1:0]   prev_bc = '0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge sdram_clk) begin
    if (sdram_write && !prev_write && nb < 64) begin
      b_addr[nb] <= sdram_address;
      b_bc[nb]   <= sdram_burstcount;
      b_wrap[nb] <= fill_wrapped;
      nb         <= nb + 1;
    end
    if (sdram_write && prev_write && prev_wait &&
        (sdram_address !== prev_addr || sdram_burstcount !== prev_bc ||
         sdram_writedata !== prev_data))
      stall_err <= stall_err + 1;
    if (sdram_write && sdram_waitrequest) nstall <= nstall + 1;
    if (sdram_write && !sdram_waitrequest) begin
      beat_data[nbeat % 256] <= sdram_writedata;
      nbeat                  <= nbeat + 1;
    end
    if (fifo_rdreq) npop <= npop + 1;
    prev_write <= sdram_write;
    prev_wait  <= sdram_waitrequest;
    prev_addr  <= sdram_address;
    prev_bc    <= sdram_burstcount;
    prev_data  <= sdram_writedata;
  end

  function automatic logic [DATA_W-1:0] word_of(input int k);
    logic [31:0] w;
    w = 32'(k) ^ 32'h5A00_0000;
    return {w, ~w, w + 32'd1, w, ~w, w + 32'd2, w, ~w};
  endfunction

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      push      = 1'b1;
      push_data = word_of(base + i);
      @(posedge sdram_clk); #1;
    end
    push = 1'b0;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e, input logic circ);
    fill_addr_start = s;
    fill_addr_end   = e;
    fill_circular   = circ;
    fill_launch     = 1'b1;
    @(posedge sdram_clk); #1;
    fill_launch     = 1'b0;
  endtask

  task automatic pulse_terminate();
    fill_terminate = 1'b1;
    @(posedge sdram_clk); #1;
    fill_terminate = 1'b0;
  endtask

  // Waits for fill_running to drop; reports the beat count seen one sample earlier.
  task automatic run_fill(input int max_cycles, input bit toggle, output bit timed_out,
                          output int prev_beats);
    int seen;
    seen       = nbeat;
    timed_out  = 1'b1;
    prev_beats = nbeat;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge sdram_clk); #1;
      if (toggle) sdram_waitrequest = ~sdram_waitrequest;
      if (!fill_running) begin
        timed_out  = 1'b0;
        prev_beats = seen;
        break;
      end
      seen = nbeat;
    end
    sdram_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    rst_sdram = 1'b1;
    repeat (3) @(posedge sdram_clk);
    #1;
    vectors++; if (sdram_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_write: got %0b want 0", sdram_write); end
    vectors++; if (fill_running !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_running: got %0b want 0", fill_running); end
    vectors++; if (fill_wrapped !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wrapped: got %0b want 0", fill_wrapped); end
    vectors++; if (fill_last_addr !== 27'h0) begin miscompares++; $display("[TB] FAIL reset_last_addr: got %0h want 0", fill_last_addr); end
    vectors++; if (sdram_address !== 27'h0) begin miscompares++; $display("[TB] FAIL reset_address: got %0h want 0", sdram_address); end
    vectors++; if (sdram_burstcount !== 8'h0) begin miscompares++; $display("[TB] FAIL reset_burstcount: got %0h want 0", sdram_burstcount); end
    vectors++; if (fifo_rdreq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdreq: got %0b want 0", fifo_rdreq); end
    vectors++; if (sdram_read !== 1'b0 || sdram_byteenable !== {(DATA_W/8){1'b1}}) begin miscompares++; $display("[TB] FAIL reset_ties: got read=%0b be=%0h want read=0 be=all ones", sdram_read, sdram_byteenable); end
    rst_sdram = 1'b0;
    @(posedge sdram_clk); #1;
  endtask

  task automatic test_one_shot_two_bursts();
    int b0, n0, p0, prev;
    bit to;
    push_words(16, 0);
    b0 = nb; n0 = nbeat; p0 = npop;
    launch(27'h100, 27'h10F, 1'b0);
    run_fill(200, 1'b0, to, prev);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL os_timeout: got running=%0b want 0", fill_running); end
    vectors++; if (nb - b0 !== 2) begin miscompares++; $display("[TB] FAIL os_bursts: got %0d want 2", nb - b0); end
    vectors++; if (b_addr[b0] !== 27'h100 || b_bc[b0] !== 8'd8) begin miscompares++; $display("[TB] FAIL os_burst0: got %0h/%0d want 100/8", b_addr[b0], b_bc[b0]); end
    vectors++; if (b_addr[b0+1] !== 27'h108 || b_bc[b0+1] !== 8'd8) begin miscompares++; $display("[TB] FAIL os_burst1: got %0h/%0d want 108/8", b_addr[b0+1], b_bc[b0+1]); end
    vectors++; if (nbeat - n0 !== 16) begin miscompares++; $display("[TB] FAIL os_beats: got %0d want 16", nbeat - n0); end
    vectors++; if (npop - p0 !== 16) begin miscompares++; $display("[TB] FAIL os_pops: got %0d want 16", npop - p0); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (beat_data[(n0 + i) % 256] !== word_of(i)) begin miscompares++; $display("[TB] FAIL os_data[%0d]: got %0h want %0h", i, beat_data[(n0 + i) % 256], word_of(i)); end
    end
    vectors++; if (prev - n0 !== 15) begin miscompares++; $display("[TB] FAIL os_running_fall: got %0d beats before fall want 15", prev - n0); end
    vectors++; if (fill_last_addr !== 27'h10F) begin miscompares++; $display("[TB] FAIL os_last_addr: got %0h want 10f", fill_last_addr); end
    vectors++; if (fifo_usedw !== 9'd0) begin miscompares++; $display("[TB] FAIL os_fifo_empty: got %0d want 0", fifo_usedw); end
  endtask

  task automatic test_waitrequest_stall();
    int b0, n0, p0, s0, prev;
    bit to;
    push_words(16, 100);
    b0 = nb; n0 = nbeat; p0 = npop; s0 = nstall;
    launch(27'h100, 27'h10F, 1'b0);
    run_fill(400, 1'b1, to, prev);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL st_timeout: got running=%0b want 0", fill_running); end
    vectors++; if (stall_err !== 0) begin miscompares++; $display("[TB] FAIL st_stable: got %0d changes while stalled want 0", stall_err); end
    vectors++; if (nstall - s0 < 1) begin miscompares++; $display("[TB] FAIL st_stalls_seen: got %0d want >0", nstall - s0); end
    vectors++; if (nb - b0 !== 2 || b_addr[b0] !== 27'h100 || b_bc[b0] !== 8'd8 ||
                   b_addr[b0+1] !== 27'h108 || b_bc[b0+1] !== 8'd8) begin
      miscompares++; $display("[TB] FAIL st_bursts: got n=%0d %0h/%0d %0h/%0d want 2 100/8 108/8",
                              nb - b0, b_addr[b0], b_bc[b0], b_addr[b0+1], b_bc[b0+1]); end
    vectors++; if (nbeat - n0 !== 16) begin miscompares++; $display("[TB] FAIL st_beats: got %0d want 16", nbeat - n0); end
    vectors++; if (npop - p0 !== 16) begin miscompares++; $display("[TB] FAIL st_pops: got %0d want 16", npop - p0); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (beat_data[(n0 + i) % 256] !== word_of(100 + i)) begin miscompares++; $display("[TB] FAIL st_data[%0d]: got %0h want %0h", i, beat_data[(n0 + i) % 256], word_of(100 + i)); end
    end
  endtask

  task automatic test_circular_wrap();
    int b0, n0, prev;
    bit to;
    logic [BC_W-1:0] exp_bc [0:3];
    logic            exp_wr [0:3];
    exp_bc = '{8'd6, 8'd6, 8'd6, 8'd2};
    exp_wr = '{1'b0, 1'b1, 1'b1, 1'b1};
    push_words(20, 1000);
    b0 = nb; n0 = nbeat;
    launch(27'h20, 27'h25, 1'b1);
    pulse_terminate();
    run_fill(400, 1'b0, to, prev);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL circ_timeout: got running=%0b want 0", fill_running); end
    vectors++; if (nb - b0 !== 4) begin miscompares++; $display("[TB] FAIL circ_bursts: got %0d want 4", nb - b0); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (b_addr[b0+i] !== 27'h20 || b_bc[b0+i] !== exp_bc[i]) begin miscompares++; $display("[TB] FAIL circ_burst%0d: got %0h/%0d want 20/%0d", i, b_addr[b0+i], b_bc[b0+i], exp_bc[i]); end
      vectors++; if (b_wrap[b0+i] !== exp_wr[i]) begin miscompares++; $display("[TB] FAIL circ_wrap%0d: got %0b want %0b", i, b_wrap[b0+i], exp_wr[i]); end
    end
    vectors++; if (nbeat - n0 !== 20) begin miscompares++; $display("[TB] FAIL circ_beats: got %0d want 20", nbeat - n0); end
    for (int i = 0; i < 20; i++) begin
      vectors++; if (beat_data[(n0 + i) % 256] !== word_of(1000 + i)) begin miscompares++; $display("[TB] FAIL circ_data[%0d]: got %0h want %0h", i, beat_data[(n0 + i) % 256], word_of(1000 + i)); end
    end
    vectors++; if (fill_last_addr !== 27'h21) begin miscompares++; $display("[TB] FAIL circ_last_addr: got %0h want 21", fill_last_addr); end
    vectors++; if (fill_wrapped !== 1'b1) begin miscompares++; $display("[TB] FAIL circ_wrapped_sticky: got %0b want 1", fill_wrapped); end
  endtask

  task automatic test_terminate_short();
    int b0, n0, prev;
    bit to;
    push_words(5, 2000);
    b0 = nb; n0 = nbeat;
    launch(27'h0, 27'h3F, 1'b0);
    pulse_terminate();
    run_fill(200, 1'b0, to, prev);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL term_timeout: got running=%0b want 0", fill_running); end
    vectors++; if (nb - b0 !== 1 || b_addr[b0] !== 27'h0 || b_bc[b0] !== 8'd5) begin miscompares++; $display("[TB] FAIL term_burst: got n=%0d %0h/%0d want 1 0/5", nb - b0, b_addr[b0], b_bc[b0]); end
    vectors++; if (nbeat - n0 !== 5) begin miscompares++; $display("[TB] FAIL term_beats: got %0d want 5", nbeat - n0); end
    vectors++; if (beat_data[(n0 + 4) % 256] !== word_of(2004)) begin miscompares++; $display("[TB] FAIL term_data4: got %0h want %0h", beat_data[(n0 + 4) % 256], word_of(2004)); end
    vectors++; if (fill_last_addr !== 27'h4) begin miscompares++; $display("[TB] FAIL term_last_addr: got %0h want 4", fill_last_addr); end
    vectors++; if (fill_wrapped !== 1'b0) begin miscompares++; $display("[TB] FAIL term_wrapped: got %0b want 0", fill_wrapped); end
  endtask

  task automatic test_reset_mid_burst();
    int b0, n0, prev;
    bit to, got2;
    push_words(16, 300);
    n0 = nbeat;
    got2 = 1'b0;
    launch(27'h200, 27'h2FF, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(posedge sdram_clk); #1;
      if (nbeat - n0 == 2) begin got2 = 1'b1; break; end
    end
    vectors++; if (!got2) begin miscompares++; $display("[TB] FAIL rst_reach_beat3: got %0d beats want 2", nbeat - n0); end
    rst_sdram = 1'b1;
    @(posedge sdram_clk); #1;
    vectors++; if (sdram_write !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_write: got %0b want 0", sdram_write); end
    vectors++; if (fill_running !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_running: got %0b want 0", fill_running); end
    vectors++; if (sdram_address !== 27'h0) begin miscompares++; $display("[TB] FAIL rst_mid_address: got %0h want 0", sdram_address); end
    vectors++; if (sdram_burstcount !== 8'h0 || fill_last_addr !== 27'h0) begin miscompares++; $display("[TB] FAIL rst_mid_bc_last: got %0d/%0h want 0/0", sdram_burstcount, fill_last_addr); end
    vectors++; if (fifo_rdreq !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_rdreq: got %0b want 0", fifo_rdreq); end
    rst_sdram  = 1'b0;
    fifo_flush = 1'b1;
    @(posedge sdram_clk); #1;
    fifo_flush = 1'b0;
    push_words(4, 400);
    b0 = nb; n0 = nbeat;
    launch(27'h300, 27'h303, 1'b0);
    run_fill(200, 1'b0, to, prev);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL rst_restart_timeout: got running=%0b want 0", fill_running); end
    vectors++; if (nb - b0 !== 1 || b_addr[b0] !== 27'h300 || b_bc[b0] !== 8'd4) begin miscompares++; $display("[TB] FAIL rst_restart_burst: got n=%0d %0h/%0d want 1 300/4", nb - b0, b_addr[b0], b_bc[b0]); end
    vectors++; if (nbeat - n0 !== 4) begin miscompares++; $display("[TB] FAIL rst_restart_beats: got %0d want 4", nbeat - n0); end
    vectors++; if (beat_data[n0 % 256] !== word_of(400)) begin miscompares++; $display("[TB] FAIL rst_restart_data0: got %0h want %0h", beat_data[n0 % 256], word_of(400)); end
    vectors++; if (fill_last_addr !== 27'h303) begin miscompares++; $display("[TB] FAIL rst_restart_last_addr: got %0h want 303", fill_last_addr); end
  endtask

  task automatic test_single_word_relaunch();
    int b0, n0, prev;
    bit to;
    push_words(1, 3000);
    b0 = nb; n0 = nbeat;
    launch(27'h7, 27'h7, 1'b0);
    fill_addr_start = 27'h50;
    fill_addr_end   = 27'h50;
    fill_launch     = 1'b1;
    @(posedge sdram_clk); #1;
    fill_launch     = 1'b0;
    run_fill(100, 1'b0, to, prev);
    repeat (4) @(posedge sdram_clk);
    #1;
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL sw_timeout: got running=%0b want 0", fill_running); end
    vectors++; if (nb - b0 !== 1 || b_addr[b0] !== 27'h7 || b_bc[b0] !== 8'd1) begin miscompares++; $display("[TB] FAIL sw_burst: got n=%0d %0h/%0d want 1 7/1", nb - b0, b_addr[b0], b_bc[b0]); end
    vectors++; if (nbeat - n0 !== 1 || beat_data[n0 % 256] !== word_of(3000)) begin miscompares++; $display("[TB] FAIL sw_beat: got n=%0d data=%0h want 1 %0h", nbeat - n0, beat_data[n0 % 256], word_of(3000)); end
    vectors++; if (fill_last_addr !== 27'h7) begin miscompares++; $display("[TB] FAIL sw_last_addr: got %0h want 7", fill_last_addr); end
    vectors++; if (fill_running !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_idle: got %0b want 0", fill_running); end
  endtask

  initial begin
    $display("[TB] sdram_burst_writer directed bench starting");
    test_reset();
    test_one_shot_two_bursts();
    test_waitrequest_stall();
    test_circular_wrap();
    test_terminate_short();
    test_reset_mid_burst();
    test_single_word_relaunch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_burst_writer.md
Name: sdram_burst_writer

Overview:
Single-clock Avalon-MM burst writer that drains a show-ahead FIFO into an SDRAM address window. It is the parametrised successor to the single-beat fill engine, and adds:
- configurable data/address width;
- burst lengths up to BURST_MAX;
- a circular (ring-buffer) capture mode with wrap reporting;
- a drain-on-terminate stop.

It sits on the sdram_clk side, after the CDC FIFO, which lives outside this block.

Parameters:
DATA_W, 256, width of FIFO word and SDRAM data bus
ADDR_W, 27, SDRAM word address width
BURST_MAX, 8, maximum beats per burst (1..2^BC_W-1)
BC_W, 8, sdram_burstcount width
LEVEL_W, 9, width of FIFO fill-level input

Ports:
sdram_clk  in  1  clock
rst_sdram  in  1  reset, synchronous, active-high
fill_launch  in  1  start pulse (already synchronous to sdram_clk)
fill_terminate  in  1  request stop after draining FIFO; level or pulse, latched sticky
fill_circular  in  1  mode, sampled at launch: 1 = wrap to start at end, 0 = one-shot
fill_addr_start  in  ADDR_W  first word address, sampled at launch
fill_addr_end  in  ADDR_W  last word address inclusive, sampled at launch; start <= end required
fill_running  out  1  high from the cycle after launch until return to IDLE
fill_wrapped  out  1  sticky: window wrapped at least once since launch
fill_last_addr  out  ADDR_W  address of the most recently accepted beat
fifo_q  in  DATA_W  FIFO head word (show-ahead)
fifo_usedw  in  LEVEL_W  FIFO occupancy in words
fifo_rdreq  out  1  pop FIFO head
sdram_address  out  ADDR_W  burst base address
sdram_burstcount  out  BC_W  beats in current burst
sdram_waitrequest  in  1  slave stall
sdram_write  out  1  write request
sdram_writedata  out  DATA_W  equals fifo_q
sdram_read  out  1  tied 0
sdram_byteenable  out  DATA_W/8  tied all ones

Behaviour:
- Reset (any cycle, including mid-burst): the next edge forces state IDLE. The following clear to 0: sdram_write, sdram_address, sdram_burstcount, fifo_rdreq (combinational, so 0), fill_running, fill_wrapped, fill_last_addr, the terminate latch and the beat counter. Dropping mid-burst is permitted only under reset.
- States: IDLE, PLAN, BURST.
- IDLE:
  - On fill_launch=1: latch start/end/circular; addr <= start; fill_wrapped <= 0; clear terminate latch; go to PLAN.
  - fill_launch is ignored in PLAN and BURST.
- Terminate latch: set whenever fill_terminate=1 in PLAN or BURST; cleared at launch and at reset.
- PLAN (one or more cycles, sdram_write=0):
  - rem = end - addr + 1, computed in ADDR_W+1 bits.
  - want = min(BURST_MAX, rem).
  - If fifo_usedw >= want: len = want.
  - Else if terminate latched and fifo_usedw > 0: len = fifo_usedw.
  - Else if terminate latched and fifo_usedw == 0: go to IDLE.
  - Else: wait in PLAN.
  - When a burst is issued: load sdram_address = addr, sdram_burstcount = len, beat counter = 0, sdram_write <= 1, go to BURST.
- BURST:
  - sdram_address and sdram_burstcount are held constant; sdram_write stays 1.
  - A beat is accepted when sdram_write && !sdram_waitrequest. In that same cycle fifo_rdreq = 1, the beat counter increments, and fill_last_addr <= sdram_address + count.
  - The FIFO cannot run empty mid-burst because len <= fifo_usedw at issue.
  - On the last accepted beat, sdram_write <= 0 and:
    - if addr + len - 1 == end and circular: addr <= start, fill_wrapped <= 1, go to PLAN;
    - if addr + len - 1 == end and one-shot: go to IDLE;
    - otherwise: addr <= addr + len, go to PLAN.
- There is a minimum one-cycle sdram_write gap between bursts (the PLAN cycle).
- A burst never crosses end; a wrap always begins a new burst at start.
- Terminate arriving mid-burst does not abort: the burst completes, then PLAN drains the remainder.
- In one-shot mode, reaching end stops the fill even if the FIFO still holds data. The leftover data stays in the FIFO.
- fill_running = (state != IDLE), registered.
- Address arithmetic is modulo 2^ADDR_W. A window of start == end is legal (single-word window).

Test Plan:
- BURST_MAX=8, start=0x100, end=0x10F, one-shot, FIFO pre-filled with 16 words, waitrequest=0 -> two bursts (addr 0x100 bc 8, addr 0x108 bc 8), 16 fifo_rdreq pulses, data order preserved, fill_running falls after the last beat, fill_last_addr=0x10F.
- Same setup with waitrequest toggling high every other cycle -> address/burstcount/writedata stable while stalled, exactly 16 beats, no extra pops.
- Circular, start=0x20, end=0x25, 20 words streamed then terminate -> bursts 0x20/6, 0x20/6, 0x20/6, 0x20/2; fill_wrapped set after the first burst; fill_last_addr=0x21.
- One-shot, start=0, end=0x3F, 5 words loaded then terminate -> single burst addr 0 bc 5, then IDLE with fill_running=0.
- Reset asserted on the 3rd beat of an 8-beat burst -> next edge sdram_write=0, fill_running=0, sdram_address=0; a fresh launch then restarts cleanly from the new start address.
- fill_launch pulsed while running, and start=end=0x7 with 1 word -> the second launch is ignored; the single-word window writes one beat bc=1 at 0x7.
